// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream blocks.
// Provides the run-state type and sizing helpers used by the
// scaled adders and their select counters.
package sc_pkg;

  // Run state shared by the SC stream blocks.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sc_state_e;

  // Default configuration of the MAC datapath adders.
  localparam int unsigned SC_N_IN_DEF  = 4;
  localparam int unsigned SC_LEN_W_DEF = 8;

  // Number of output bits in one run for a given log2 length.
  function automatic int unsigned sc_stream_len(input int unsigned len_w);
    return 32'd1 << len_w;
  endfunction

  // Select width for an N-way round robin; never narrower than one bit.
  function automatic int unsigned sc_sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sc_sel_ctr.sv
// Modulo-N_IN round-robin select counter with advance enable and
// synchronous clear. Clear has priority over advance.
module sc_sel_ctr
  import sc_pkg::*;
#(
  parameter  int unsigned N_IN  = SC_N_IN_DEF,
  localparam int unsigned SEL_W = sc_sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [SEL_W-1:0] sel_o
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  // Next select: clear, wrap at the last channel, or step by one.
  always_comb begin
    sel_d = sel_q;
    if (clr_i) begin
      sel_d = '0;
    end else if (adv_i) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
  end

  // Select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/sc_sum_n.sv
// N-input deterministic stochastic-computing scaled adder.
// Each run emits 2^LEN_W bits; the select visits channels 0..N_IN-1 in
// order, so every channel is sampled equally often and the output stream
// encodes the exact mean of the inputs.
// Optional macro SC_SUM_CNT_EN adds the ones_cnt run counter port.
module sc_sum_n
  import sc_pkg::*;
#(
  parameter  int unsigned N_IN  = SC_N_IN_DEF,
  parameter  int unsigned LEN_W = SC_LEN_W_DEF,
  localparam int unsigned SEL_W = sc_sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [N_IN-1:0]  x_sn,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] sel_o
`ifdef SC_SUM_CNT_EN
  ,
  output logic [LEN_W:0]   ones_cnt
`endif
);

  localparam logic [LEN_W-1:0] LAST_BIT = '1;

  sc_state_e        state_q, state_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             done_q, done_d;
  logic             sel_clr;
  logic             sel_adv;
  logic [SEL_W-1:0] sel;
  logic             sample_bit;

  sc_sel_ctr #(
    .N_IN (N_IN)
  ) u_sel_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sel_clr),
    .adv_i (sel_adv),
    .sel_o (sel)
  );

  assign sample_bit = x_sn[sel];

  // Run control: accept start in IDLE, capture one bit per enabled edge in RUN.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    done_d    = 1'b0;
    sel_clr   = 1'b0;
    sel_adv   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_clr   = 1'b1;
        bit_cnt_d = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          q_d       = sample_bit;
          q_valid_d = 1'b1;
          sel_adv   = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bit counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);
  assign sel_o   = sel;

`ifdef SC_SUM_CNT_EN
  logic [LEN_W:0] ones_q, ones_d;

  // Ones counter: cleared when a run is accepted, held after done.
  always_comb begin
    ones_d = ones_q;
    if (state_q == IDLE && start) begin
      ones_d = '0;
    end else if (state_q == RUN && en && sample_bit) begin
      ones_d = ones_q + 1'b1;
    end
  end

  // Ones counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_cnt = ones_q;
`endif

endmodule

// File: tb/tb_sc_sum_n.sv
// Directed bench for sc_sum_n: one instance with N_IN=4/LEN_W=4 and one
// with N_IN=2/LEN_W=3. Expected values are hand-derived per scenario.
module tb_sc_sum_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 1'b0, en_a = 1'b0;
  logic [3:0] x_a = '0;
  logic       q_a, q_valid_a, busy_a, done_a;
  logic [1:0] sel_a;

  logic       start_b = 1'b0, en_b = 1'b0;
  logic [1:0] x_b = '0;
  logic       q_b, q_valid_b, busy_b, done_b;
  logic [0:0] sel_b;

`ifdef SC_SUM_CNT_EN
  logic [4:0] ones_a;
  logic [3:0] ones_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sc_sum_n #(.N_IN(4), .LEN_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .en(en_a), .x_sn(x_a),
    .q(q_a), .q_valid(q_valid_a), .busy(busy_a), .done(done_a), .sel_o(sel_a)
`ifdef SC_SUM_CNT_EN
    , .ones_cnt(ones_a)
`endif
  );

  sc_sum_n #(.N_IN(2), .LEN_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .en(en_b), .x_sn(x_b),
    .q(q_b), .q_valid(q_valid_b), .busy(busy_b), .done(done_b), .sel_o(sel_b)
`ifdef SC_SUM_CNT_EN
    , .ones_cnt(ones_b)
`endif
  );

  // Observation vectors: {q_valid, q, done, busy, sel}
  logic [5:0] obs_a;
  logic [4:0] obs_b;
  assign obs_a = {q_valid_a, q_a, done_a, busy_a, sel_a};
  assign obs_b = {q_valid_b, q_b, done_b, busy_b, sel_b};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if (obs_a !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_a obs=%b exp=%b", obs_a, 6'b0);
    end
    vectors++;
    if (obs_b !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_b obs=%b exp=%b", obs_b, 5'b0);
    end
`ifdef SC_SUM_CNT_EN
    vectors++;
    if (ones_a !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_ones obs=%0d exp=0", ones_a);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  // Plan 1: x=0001, continuous enable.
  task automatic test_basic();
    logic [5:0] exp;
    int ones;
    x_a = 4'b0001; en_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    vectors++;
    if (obs_a !== 6'b000100) begin
      miscompares++;
      $display("FAIL basic_accept obs=%b exp=%b", obs_a, 6'b000100);
    end
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = {1'b1, (k % 4) == 0, k == 15, k != 15, 2'((k + 1) % 4)};
      ones += int'(q_a);
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL basic_bit k=%0d obs=%b exp=%b", k, obs_a, exp);
      end
    end
    vectors++;
    if (ones != 4) begin
      miscompares++;
      $display("FAIL basic_ones obs=%0d exp=4", ones);
    end
`ifdef SC_SUM_CNT_EN
    vectors++;
    if (ones_a !== 5'd4) begin
      miscompares++;
      $display("FAIL basic_ones_cnt obs=%0d exp=4", ones_a);
    end
`endif
    step();
    vectors++;
    if (obs_a !== 6'b000000) begin
      miscompares++;
      $display("FAIL basic_idle obs=%b exp=%b", obs_a, 6'b000000);
    end
    $display("test_basic done, ones=%0d", ones);
  endtask

  // Plan 2: enable toggles every cycle; 16 bits over 31 cycles.
  task automatic test_stall();
    logic [5:0] exp;
    logic last_q, eq, ev, ed;
    int k, done_seen, exp_ones;
    x_a = 4'b0001; en_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 0; last_q = 1'b0; done_seen = 0; exp_ones = 0;
    for (int j = 0; j < 31; j++) begin
      en_a = (j % 2 == 0);
      step();
      ed = 1'b0;
      if (j % 2 == 0) begin
        eq = ((k % 4) == 0);
        ev = 1'b1;
        exp_ones += int'(eq);
        k++;
        ed = (k == 16);
      end else begin
        eq = last_q;
        ev = 1'b0;
      end
      exp = {ev, eq, ed, k != 16, 2'(k % 4)};
      done_seen += int'(done_a);
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL stall_cycle j=%0d obs=%b exp=%b", j, obs_a, exp);
      end
`ifdef SC_SUM_CNT_EN
      vectors++;
      if (ones_a !== 5'(exp_ones)) begin
        miscompares++;
        $display("FAIL stall_ones_cnt j=%0d obs=%0d exp=%0d", j, ones_a, exp_ones);
      end
`endif
      last_q = eq;
    end
    vectors++;
    if (done_seen != 1) begin
      miscompares++;
      $display("FAIL stall_done_count obs=%0d exp=1", done_seen);
    end
    en_a = 1'b1;
    $display("test_stall done, done pulses=%0d", done_seen);
  endtask

  // Plan 3: all inputs high, 16 ones with no counter wrap.
  task automatic test_all_ones();
    int ones;
    x_a = 4'b1111; en_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      ones += int'(q_a & q_valid_a);
      vectors++;
      if ({q_valid_a, q_a, done_a} !== {2'b11, k == 15}) begin
        miscompares++;
        $display("FAIL ones_bit k=%0d obs=%b exp=%b", k, {q_valid_a, q_a, done_a}, {2'b11, k == 15});
      end
    end
    vectors++;
    if (ones != 16) begin
      miscompares++;
      $display("FAIL ones_total obs=%0d exp=16", ones);
    end
`ifdef SC_SUM_CNT_EN
    vectors++;
    if (ones_a !== 5'h10) begin
      miscompares++;
      $display("FAIL ones_cnt_full obs=%0d exp=16", ones_a);
    end
`endif
    $display("test_all_ones done, ones=%0d", ones);
  endtask

  // Plan 4: asynchronous reset mid-run, then a clean restart.
  task automatic test_async_reset();
    logic [5:0] exp;
    x_a = 4'b1111; en_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 7; k++) step();
    #2;
    vectors++;
    if (obs_a !== 6'b110111) begin
      miscompares++;
      $display("FAIL arst_before obs=%b exp=%b", obs_a, 6'b110111);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_a !== 6'b000000) begin
      miscompares++;
      $display("FAIL arst_immediate obs=%b exp=%b", obs_a, 6'b000000);
    end
`ifdef SC_SUM_CNT_EN
    vectors++;
    if (ones_a !== 5'd0) begin
      miscompares++;
      $display("FAIL arst_ones_cnt obs=%0d exp=0", ones_a);
    end
`endif
    #2;
    rst_n = 1'b1;
    x_a = 4'b0001; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = {1'b1, (k % 4) == 0, k == 15, k != 15, 2'((k + 1) % 4)};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL arst_restart k=%0d obs=%b exp=%b", k, obs_a, exp);
      end
    end
    $display("test_async_reset done");
  endtask

  // Plan 5: start held high; re-accepted in the done cycle.
  task automatic test_back_to_back();
    logic [5:0] exp;
    int nvalid;
    x_a = 4'b0001; en_a = 1'b1; start_a = 1'b1;
    step();
    vectors++;
    if (obs_a !== 6'b000100) begin
      miscompares++;
      $display("FAIL b2b_accept obs=%b exp=%b", obs_a, 6'b000100);
    end
    for (int r = 0; r < 2; r++) begin
      nvalid = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        nvalid += int'(q_valid_a);
        exp = {1'b1, (k % 4) == 0, k == 15, k != 15, 2'((k + 1) % 4)};
        vectors++;
        if (obs_a !== exp) begin
          miscompares++;
          $display("FAIL b2b_bit r=%0d k=%0d obs=%b exp=%b", r, k, obs_a, exp);
        end
      end
      vectors++;
      if (nvalid != 16) begin
        miscompares++;
        $display("FAIL b2b_valid_count r=%0d obs=%0d exp=16", r, nvalid);
      end
      if (r == 1) start_a = 1'b0;
      step();
      exp = {4'b0000, 2'b00};
      exp[2] = (r == 0);
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL b2b_after_done r=%0d obs=%b exp=%b", r, obs_a, exp);
      end
    end
    $display("test_back_to_back done");
  endtask

  // Plan 6: N_IN=2, LEN_W=3 instance.
  task automatic test_n2();
    logic [4:0] exp;
    logic [7:0] exp_q;
    int ones;
    exp_q = 8'b0001_0001;  // bit k = expected q for slot k: 1,0,0,0,1,0,0,0
    x_b = 2'b01; en_b = 1'b1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    vectors++;
    if (obs_b !== 5'b00010) begin
      miscompares++;
      $display("FAIL n2_accept obs=%b exp=%b", obs_b, 5'b00010);
    end
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      x_b[0] = ((k % 4) < 2);
      x_b[1] = 1'b0;
      step();
      ones += int'(q_b);
      exp = {1'b1, exp_q[k], k == 7, k != 7, 1'((k + 1) % 2)};
      vectors++;
      if (obs_b !== exp) begin
        miscompares++;
        $display("FAIL n2_bit k=%0d obs=%b exp=%b", k, obs_b, exp);
      end
    end
    vectors++;
    if (ones != 2) begin
      miscompares++;
      $display("FAIL n2_ones obs=%0d exp=2", ones);
    end
`ifdef SC_SUM_CNT_EN
    vectors++;
    if (ones_b !== 4'd2) begin
      miscompares++;
      $display("FAIL n2_ones_cnt obs=%0d exp=2", ones_b);
    end
`endif
    $display("test_n2 done, ones=%0d", ones);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_all_ones();
    test_async_reset();
    test_back_to_back();
    test_n2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sc_sum_n.md
Name: sc_sum_n

Overview:
- N-input deterministic stochastic-computing scaled adder. Successor of the 2-input MUX-select adder.
- Generates its own select internally: a round-robin counter over a fixed-length stream of 2^LEN_W bits.
- Registered output bit-stream encodes the mean of the N input probabilities exactly, because stream length is a multiple of N.
- Sits between the SC multiplier array and the stream-to-binary counter stage of the MAC datapath.

Parameters:
- N_IN, 4, number of input bit-streams; power of two, 2 ≤ N_IN ≤ 2^LEN_W.
- LEN_W, 8, log2 of stream length; one run = 2^LEN_W output bits.
- SEL_W, $clog2(N_IN), select width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; accepted only in IDLE
- en  in  1  advance enable; low = stall
- x_sn  in  N_IN  input bit-streams, bit i = channel i
- q  out  1  registered scaled-sum bit
- q_valid  out  1  q holds a new stream bit this cycle
- busy  out  1  run in progress
- done  out  1  one-cycle pulse with final stream bit
- sel_o  out  SEL_W  channel that will be sampled next edge
- ones_cnt  out  LEN_W+1  count of 1s in current/last run (SC_SUM_CNT_EN only)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - q, q_valid, busy, done, sel_o, bit counter and ones_cnt all 0.
  - Takes effect immediately, including mid-run. There is no resume; a new start is required.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at an edge → RUN.
  - sel=0, bit_cnt=0, ones_cnt=0.
  - Nothing is sampled on that edge.
  - q_valid=0 and done=0 while idle.
  - q holds its last value.
- RUN, with en=1 at an edge:
  - q ← x_sn[sel]; q_valid ← 1.
  - sel ← (sel+1) mod N_IN.
  - bit_cnt ← bit_cnt+1.
  - Latency from x_sn sample to q is 1 cycle.
- RUN, with en=0: q, sel, bit_cnt, ones_cnt hold; q_valid ← 0.
- Final bit (bit_cnt = 2^LEN_W−1 and en=1):
  - Capture the bit as above.
  - done ← 1 for exactly one cycle, coincident with that q_valid.
  - state → IDLE, so busy is low in the done cycle.
  - sel and bit_cnt wrap to 0.
- busy = (state==RUN); it is high from the cycle after start is accepted.
- start while in RUN is ignored.
- start asserted in the done cycle (state already IDLE) is accepted; the next run begins with no gap cycle.
- Every run samples each channel exactly 2^LEN_W/N_IN times, in order 0,1,…,N_IN−1 repeating.
- Output ones = Σ_i (ones of x_sn[i] at its sample slots).
- sel_o is the registered sel; it is valid in IDLE (0) and during stalls.

Optional Feature:
- Macro: SC_SUM_CNT_EN.
- Defined:
  - ones_cnt port present.
  - Cleared on start acceptance; +1 on each RUN edge with en=1 and captured bit=1.
  - Holds after done until the next accepted start.
  - Width LEN_W+1 so 2^LEN_W ones never overflows.
- Undefined: ones_cnt port and counter logic absent; all other behaviour identical.

Decomposition:
- Package sc_pkg:
  - state typedef (IDLE, RUN).
  - Localparam helpers for stream length, 2^LEN_W, and SEL_W.
  - Shared with other SC stream blocks.
- Sub-module sc_sel_ctr: modulo-N_IN round-robin select counter with enable and synchronous clear. Reused by the future weighted-select variant.
- FSM, bit counter and output register remain in sc_sum_n.

Test Plan:
1. N_IN=4, LEN_W=4; x_sn=4'b0001 constant; start, en=1 → q = 1,0,0,0 ×4; 16 q_valid pulses; done with 16th; ones_cnt=4.
2. Same config; en toggles 1/0 every cycle → 16 valid bits over 31 cycles; q, sel_o and ones_cnt frozen during en=0; done once.
3. x_sn=4'b1111 → 16 ones; ones_cnt=16 (0x10, no wrap); q constant 1.
4. rst_n pulsed low after 7 valid bits → q, q_valid, busy, sel_o, ones_cnt go to 0 without waiting for a clock edge; a new start restarts at sel=0 with 16 full bits.
5. start held high throughout a run → ignored while busy; re-accepted in the done cycle; next q_valid follows with no idle gap; two done pulses 16 valid bits apart.
6. N_IN=2, LEN_W=3; x_sn[0] = stream 1,1,0,0,…, x_sn[1] = all 0 → q = 1,0,0,0,1,0,0,0; ones_cnt=2.
